// File: rtl/arm_mem_arb_pkg.sv
// Shared types and widths for the fetch/data memory arbiter.
package arm_mem_arb_pkg;

   localparam int ARM_WORD_ADDR_W = 30;
   localparam int ARM_DATA_W      = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                       we;
      logic [ARM_WORD_ADDR_W-1:0] addr;
      logic [ARM_DATA_W-1:0]      wdata;
   } mem_cmd_t;

endpackage

// File: rtl/arm_mem_arb_pick.sv
// Winner select: data has priority unless fetch has been starved to the limit.
module arm_mem_arb_pick (
   input  logic if_req,
   input  logic d_req,
   input  logic starved,
   output logic pick_i,
   output logic pick_d
);

   assign pick_d = d_req && !(if_req && starved);
   assign pick_i = if_req && !pick_d;

endmodule

// File: rtl/arm_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Optional wait-cycle statistics ports are built when ARM_MEM_ARB_STATS_EN is defined.
module arm_mem_arbiter
   import arm_mem_arb_pkg::*;
#(
   parameter int MAX_STARVE     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       if_req,
   input  logic [ARM_WORD_ADDR_W-1:0] if_addr,
   output logic                       if_gnt,
   output logic                       if_valid,
   output logic [ARM_DATA_W-1:0]      if_rdata,
   input  logic                       d_req,
   input  logic                       d_we,
   input  logic [ARM_WORD_ADDR_W-1:0] d_addr,
   input  logic [ARM_DATA_W-1:0]      d_wdata,
   output logic                       d_gnt,
   output logic                       d_valid,
   output logic [ARM_DATA_W-1:0]      d_rdata,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ARM_WORD_ADDR_W-1:0] mem_addr,
   output logic [ARM_DATA_W-1:0]      mem_wdata,
   input  logic [ARM_DATA_W-1:0]      mem_rdata,
   input  logic                       mem_ready,
`ifdef ARM_MEM_ARB_STATS_EN
   input  logic                       stats_clr,
   output logic [15:0]                if_wait_cnt,
   output logic [15:0]                d_wait_cnt,
`endif
   output logic                       timeout_err
);

   arb_state_e state, state_nxt;
   mem_cmd_t   cmd_q, cmd_nxt;
   logic [3:0] starve_cnt;
   logic [7:0] tmo_cnt;
   logic       pick_i, pick_d, starved, busy, abort, done;
   logic       if_gnt_nxt, d_gnt_nxt, if_valid_nxt, d_valid_nxt, mem_req_nxt, tmo_err_nxt;
   logic [ARM_DATA_W-1:0] rd_val, if_rdata_nxt, d_rdata_nxt;

   assign starved = (starve_cnt == 4'(MAX_STARVE));
   assign busy    = (state != IDLE);
   // A completion arriving on the last allowed cycle beats the timeout.
   assign abort   = busy && (TIMEOUT_CYCLES != 0) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) && !mem_ready;
   assign done    = busy && (mem_ready || abort);
   assign rd_val  = mem_ready ? mem_rdata : '0;

   arm_mem_arb_pick u_pick (
      .if_req  (if_req),
      .d_req   (d_req),
      .starved (starved),
      .pick_i  (pick_i),
      .pick_d  (pick_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:          if (pick_i)      state_nxt = BUSY_I;
                        else if (pick_d) state_nxt = BUSY_D;
         BUSY_I, BUSY_D: if (done)       state_nxt = IDLE;
         default:       state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if_gnt_nxt   = (state == IDLE) && pick_i;
      d_gnt_nxt    = (state == IDLE) && pick_d;
      if_valid_nxt = (state == BUSY_I) && done;
      d_valid_nxt  = (state == BUSY_D) && done;
      mem_req_nxt  = (state == IDLE) ? (pick_i || pick_d) : !done;
      tmo_err_nxt  = timeout_err || abort;
      cmd_nxt      = cmd_q;
      if_rdata_nxt = if_rdata;
      d_rdata_nxt  = d_rdata;
      if (if_gnt_nxt) cmd_nxt = '{we: 1'b0, addr: if_addr, wdata: '0};
      if (d_gnt_nxt)  cmd_nxt = '{we: d_we, addr: d_addr, wdata: d_wdata};
      if (if_valid_nxt) if_rdata_nxt = rd_val;
      if (d_valid_nxt)  d_rdata_nxt  = cmd_q.we ? '0 : rd_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_gnt      <= 1'b0;
         d_gnt       <= 1'b0;
         if_valid    <= 1'b0;
         d_valid     <= 1'b0;
         mem_req     <= 1'b0;
         timeout_err <= 1'b0;
         cmd_q       <= '0;
         if_rdata    <= '0;
         d_rdata     <= '0;
      end else begin
         if_gnt      <= if_gnt_nxt;
         d_gnt       <= d_gnt_nxt;
         if_valid    <= if_valid_nxt;
         d_valid     <= d_valid_nxt;
         mem_req     <= mem_req_nxt;
         timeout_err <= tmo_err_nxt;
         cmd_q       <= cmd_nxt;
         if_rdata    <= if_rdata_nxt;
         d_rdata     <= d_rdata_nxt;
      end
   end

   assign mem_we    = cmd_q.we;
   assign mem_addr  = cmd_q.addr;
   assign mem_wdata = cmd_q.wdata;

   // Starvation only accrues when data beats a waiting fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (if_gnt_nxt)
         starve_cnt <= '0;
      else if (d_gnt_nxt && if_req && !starved)
         starve_cnt <= starve_cnt + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                tmo_cnt <= '0;
      else if (!busy || done)                    tmo_cnt <= '0;
      else if (tmo_cnt != 8'hFF)                 tmo_cnt <= tmo_cnt + 8'd1;
   end

`ifdef ARM_MEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_wait_cnt <= '0;
         d_wait_cnt  <= '0;
      end else if (stats_clr) begin
         if_wait_cnt <= '0;
         d_wait_cnt  <= '0;
      end else begin
         if (if_req && !if_gnt && if_wait_cnt != 16'hFFFF) if_wait_cnt <= if_wait_cnt + 16'd1;
         if (d_req && !d_gnt && d_wait_cnt != 16'hFFFF)    d_wait_cnt  <= d_wait_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Directed bench for arm_mem_arbiter: vector table plus starvation, timeout and reset sequences.
module tb_arm_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, d_req, d_we, mem_ready;
   logic [29:0] if_addr, d_addr;
   logic [31:0] d_wdata, mem_rdata;
   logic        if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we, timeout_err;
   logic [31:0] if_rdata, d_rdata, mem_wdata;
   logic [29:0] mem_addr;
`ifdef ARM_MEM_ARB_STATS_EN
   logic        stats_clr;
   logic [15:0] if_wait_cnt, d_wait_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   arm_mem_arbiter #(.MAX_STARVE(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef ARM_MEM_ARB_STATS_EN
      .stats_clr(stats_clr), .if_wait_cnt(if_wait_cnt), .d_wait_cnt(d_wait_cnt),
`endif
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic        is_d;
      logic        we;
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          waits;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];
   int   exp_seq[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One isolated transaction; v.waits extra BUSY cycles before mem_ready.
   task automatic do_txn(input vec_t v);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      mem_ready = 1'b0;
      mem_rdata = v.mrdata;
      tick();
      chk("gnt_i", 32'(if_gnt), 32'(!v.is_d));
      chk("gnt_d", 32'(d_gnt), 32'(v.is_d));
      chk("mem_req_on", 32'(mem_req), 32'd1);
      chk("mem_addr", 32'(mem_addr), 32'(v.addr));
      chk("mem_we", 32'(mem_we), 32'(v.is_d && v.we));
      if (v.is_d && v.we) chk("mem_wdata", mem_wdata, v.wdata);
      if_req = 1'b0; d_req = 1'b0;
      for (int k = 0; k < v.waits; k++) begin
         chk("wait_mem_req", 32'(mem_req), 32'd1);
         chk("wait_no_valid", 32'(if_valid || d_valid), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("valid_i", 32'(if_valid), 32'(!v.is_d));
      chk("valid_d", 32'(d_valid), 32'(v.is_d));
      chk("rdata", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
      chk("mem_req_off", 32'(mem_req), 32'd0);
   endtask

   initial begin
      int   n, cnt;
      vec_t fv;

      vecs[0] = '{1'b0, 1'b0, 30'h10,       32'h0,        32'hE3A00001, 0, 32'hE3A00001};
      vecs[1] = '{1'b1, 1'b1, 30'h20,       32'hCAFEF00D, 32'h12345678, 0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 30'h3FFFFFFF, 32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF};
      vecs[3] = '{1'b0, 1'b0, 30'h0,        32'h0,        32'hFFFFFFFF, 7, 32'hFFFFFFFF};
      vecs[4] = '{1'b1, 1'b0, 30'h1,        32'h0,        32'h0BADF00D, 1, 32'h0BADF00D};
      exp_seq = '{1, 1, 1, 1, 0, 1};

      rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
`ifdef ARM_MEM_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      tick(); tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
      chk("rst_valid", 32'({if_valid, d_valid}), 32'd0);
      chk("rst_tmo_err", 32'(timeout_err), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) do_txn(vecs[i]);
      tick();
      chk("valid_pulse", 32'(if_valid || d_valid), 32'd0);
      chk("no_tmo_err", 32'(timeout_err), 32'd0);

      // Both requesters held, zero-wait memory.
      if_req = 1'b1; if_addr = 30'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h200;
      mem_ready = 1'b1; mem_rdata = 32'h11112222;
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         tick();
         if (if_gnt || d_gnt) begin
            chk("starve_order", 32'(d_gnt), 32'(exp_seq[n]));
            chk("starve_addr", 32'(mem_addr), d_gnt ? 32'h200 : 32'h100);
            if (if_gnt) chk("starve_clr", 32'(dut.starve_cnt), 32'd0);
            n++;
         end
      end
      chk("starve_grants", 32'(n), 32'd6);
      if_req = 1'b0; d_req = 1'b0;
      tick(); tick();
      mem_ready = 1'b0;

      // Timeout: mem_ready never comes.
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h44; mem_rdata = 32'h5555AAAA;
      tick();
      chk("tmo_gnt", 32'(d_gnt), 32'd1);
      d_req = 1'b0;
      cnt = 0;
      while (mem_req && cnt < 50) begin
         cnt++;
         tick();
      end
      chk("tmo_len", 32'(cnt), 32'd8);
      chk("tmo_valid", 32'(d_valid), 32'd1);
      chk("tmo_rdata", d_rdata, 32'd0);
      chk("tmo_err_set", 32'(timeout_err), 32'd1);
      fv = '{1'b0, 1'b0, 30'h55, 32'h0, 32'hA5A5A5A5, 1, 32'hA5A5A5A5};
      do_txn(fv);
      chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

      // Reset in the middle of a data wait.
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h3;
      tick();
      d_req = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_busy", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_mem_req", 32'(mem_req), 32'd0);
      chk("arst_gnt_valid", 32'({if_gnt, d_gnt, if_valid, d_valid}), 32'd0);
      chk("arst_tmo_cnt", 32'(dut.tmo_cnt), 32'd0);
      chk("arst_starve", 32'(dut.starve_cnt), 32'd0);
      chk("arst_tmo_err", 32'(timeout_err), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_idle", 32'(mem_req), 32'd0);
      fv = '{1'b0, 1'b0, 30'h77, 32'h0, 32'h600DCAFE, 0, 32'h600DCAFE};
      do_txn(fv);

`ifdef ARM_MEM_ARB_STATS_EN
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      if_req = 1'b1; if_addr = 30'h8; d_req = 1'b1; d_we = 1'b1; d_addr = 30'h5; d_wdata = 32'h1;
      mem_ready = 1'b0;
      tick();
      chk("st_d_gnt", 32'(d_gnt), 32'd1);
      d_req = 1'b0;
      tick(); tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      chk("st_if_gnt", 32'(if_gnt), 32'd1);
      chk("st_if_wait", 32'(if_wait_cnt), 32'd5);
      chk("st_d_wait", 32'(d_wait_cnt), 32'd1);
      if_req = 1'b0; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0; if_req = 1'b1; stats_clr = 1'b1;
      tick();
      chk("st_clr_if", 32'(if_wait_cnt), 32'd0);
      chk("st_clr_d", 32'(d_wait_cnt), 32'd0);
      chk("st_clr_gnt", 32'(if_gnt), 32'd1);
      stats_clr = 1'b0; if_req = 1'b0; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
